// File: rtl/twiddle_seq_gen.sv
// Streaming radix-2 DIT twiddle generator: quarter-wave cosine ROM plus symmetry fixup,
// three-register pipe (issue/P1, P2+output). Define TWGEN_INV_EN to add the 'inverse' port.
module twiddle_seq_gen #(
   parameter int LOG2N = 4,
   parameter int DW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4:0]        stage,
`ifdef TWGEN_INV_EN
   input  logic              inverse,
`endif
   output logic              busy,
   output logic              tw_valid,
   input  logic              tw_ready,
   output logic [2*DW-1:0]   tw_data,
   output logic [LOG2N-2:0]  tw_idx,
   output logic              tw_last,
   output logic              done
);
   localparam int N    = 1 << LOG2N;
   localparam int HALF = N / 2;
   localparam int QTR  = N / 4;
   localparam int JW   = LOG2N - 1;
   localparam longint PI_Q30 = 64'sd3373259426;

   // Integer Taylor series in Q30 so the table is built without real arithmetic.
   function automatic logic signed [DW-1:0] cos_q(input int i);
      longint x, x2, term, acc, scaled;
      x    = (PI_Q30 * 64'sd2 * longint'(i)) / longint'(N);
      x2   = (x * x) >>> 30;
      term = 64'sd1 <<< 30;
      acc  = term;
      for (int n = 1; n <= 12; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
         acc  = acc + term;
      end
      scaled = (acc * (64'sd1 <<< (DW - 2)) + (64'sd1 <<< 29)) >>> 30;
      return scaled[DW-1:0];
   endfunction

   logic signed [DW-1:0] rom [0:QTR];

   for (genvar gi = 0; gi <= QTR; gi++) begin : g_rom
      localparam logic signed [DW-1:0] QV = cos_q(gi);
      assign rom[gi] = QV;
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [JW-1:0]   j_q, j_d;
   logic [4:0]      stage_q, stage_d;
   logic [1:0]      vld_pipe_q, vld_pipe_d;
   logic [JW-1:0]   p1_k_q, p1_k_d;
   logic [JW-1:0]   p1_are_q, p1_are_d;
   logic [JW-1:0]   p1_aim_q, p1_aim_d;
   logic            p1_nre_q, p1_nre_d;
   logic            p1_nim_q, p1_nim_d;
   logic            p1_last_q, p1_last_d;
   logic [2*DW-1:0] tw_data_q, tw_data_d;
   logic [JW-1:0]   tw_idx_q, tw_idx_d;
   logic            tw_last_q, tw_last_d;
   logic            done_q, done_d;
   logic            inv_c;

`ifdef TWGEN_INV_EN
   logic inv_q, inv_d;
   assign inv_c = inv_q;
`else
   assign inv_c = 1'b0;
`endif

   logic            adv, issue, hs_last;
   logic [JW-1:0]   mask, k_c;
   logic [4:0]      shamt;
   logic signed [DW-1:0] re_c, im_c;

   assign adv     = !vld_pipe_q[1] || tw_ready;
   assign issue   = (state_q == S_RUN) && adv;
   assign hs_last = vld_pipe_q[1] && tw_ready && tw_last_q;

   // P1: butterfly index to twiddle exponent, then fold into the quarter-wave table.
   always_comb begin
      mask  = JW'((32'd1 << stage_q) - 32'd1);
      shamt = 5'(JW) - stage_q;
      k_c   = (j_q & mask) << shamt;
      p1_k_d    = k_c;
      p1_last_d = (j_q == JW'(HALF - 1));
      p1_nim_d  = !inv_c;
      if (k_c <= JW'(QTR)) begin
         p1_are_d = k_c;
         p1_aim_d = JW'(QTR) - k_c;
         p1_nre_d = 1'b0;
      end else begin
         p1_are_d = JW'(QTR) - (k_c - JW'(QTR));
         p1_aim_d = k_c - JW'(QTR);
         p1_nre_d = 1'b1;
      end
   end

   // P2: table read and sign fixup; table never holds the most negative value.
   always_comb begin
      re_c = p1_nre_q ? -rom[p1_are_q] : rom[p1_are_q];
      im_c = p1_nim_q ? -rom[p1_aim_q] : rom[p1_aim_q];
   end

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      stage_d = stage_q;
      done_d  = 1'b0;
`ifdef TWGEN_INV_EN
      inv_d   = inv_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               j_d     = '0;
               stage_d = (stage >= 5'(LOG2N)) ? 5'(LOG2N - 1) : stage;
`ifdef TWGEN_INV_EN
               inv_d   = inverse;
`endif
            end
         end
         S_RUN: begin
            if (issue) begin
               j_d = j_q + JW'(1);
               if (j_q == JW'(HALF - 1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (hs_last) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The whole pipe moves together; a stalled output freezes every stage behind it.
   logic [JW-1:0]  p1_k_n, p1_are_n, p1_aim_n;
   logic           p1_nre_n, p1_nim_n, p1_last_n;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      p1_k_n     = p1_k_q;
      p1_are_n   = p1_are_q;
      p1_aim_n   = p1_aim_q;
      p1_nre_n   = p1_nre_q;
      p1_nim_n   = p1_nim_q;
      p1_last_n  = p1_last_q;
      tw_data_d  = tw_data_q;
      tw_idx_d   = tw_idx_q;
      tw_last_d  = tw_last_q;
      if (adv) begin
         vld_pipe_d = {vld_pipe_q[0], issue};
         if (issue) begin
            p1_k_n    = p1_k_d;
            p1_are_n  = p1_are_d;
            p1_aim_n  = p1_aim_d;
            p1_nre_n  = p1_nre_d;
            p1_nim_n  = p1_nim_d;
            p1_last_n = p1_last_d;
         end
         if (vld_pipe_q[0]) begin
            tw_data_d = {re_c, im_c};
            tw_idx_d  = p1_k_q;
            tw_last_d = p1_last_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         j_q        <= '0;
         stage_q    <= '0;
         vld_pipe_q <= '0;
         p1_k_q     <= '0;
         p1_are_q   <= '0;
         p1_aim_q   <= '0;
         p1_nre_q   <= 1'b0;
         p1_nim_q   <= 1'b0;
         p1_last_q  <= 1'b0;
         tw_data_q  <= '0;
         tw_idx_q   <= '0;
         tw_last_q  <= 1'b0;
         done_q     <= 1'b0;
`ifdef TWGEN_INV_EN
         inv_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         j_q        <= j_d;
         stage_q    <= stage_d;
         vld_pipe_q <= vld_pipe_d;
         p1_k_q     <= p1_k_n;
         p1_are_q   <= p1_are_n;
         p1_aim_q   <= p1_aim_n;
         p1_nre_q   <= p1_nre_n;
         p1_nim_q   <= p1_nim_n;
         p1_last_q  <= p1_last_n;
         tw_data_q  <= tw_data_d;
         tw_idx_q   <= tw_idx_d;
         tw_last_q  <= tw_last_d;
         done_q     <= done_d;
`ifdef TWGEN_INV_EN
         inv_q      <= inv_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign tw_valid = vld_pipe_q[1];
   assign tw_data  = tw_data_q;
   assign tw_idx   = tw_idx_q;
   assign tw_last  = tw_last_q;
   assign done     = done_q;

endmodule

// File: tb/tb_twiddle_seq_gen.sv
// Bench for twiddle_seq_gen: directed steps plus randomized stages/back-pressure,
// checked against a trig-based reference computed from W_N^k directly.
module tb_twiddle_seq_gen;
   localparam int  LOG2N = 4;
   localparam int  DW    = 16;
   localparam int  N     = 1 << LOG2N;
   localparam int  HALF  = N / 2;
   localparam real PI    = 3.14159265358979323846;
   localparam real UNITY = 16384.0;

   logic              clk = 1'b0;
   logic              rst, start, tw_ready;
   logic [4:0]        stage;
   logic              busy, tw_valid, tw_last, done;
   logic [2*DW-1:0]   tw_data;
   logic [LOG2N-2:0]  tw_idx;
`ifdef TWGEN_INV_EN
   logic              inverse;
`endif
   bit                inv_sel;
   int                n_assert = 0;
   int                n_fail   = 0;

   twiddle_seq_gen #(.LOG2N(LOG2N), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stage    (stage),
`ifdef TWGEN_INV_EN
      .inverse  (inverse),
`endif
      .busy     (busy),
      .tw_valid (tw_valid),
      .tw_ready (tw_ready),
      .tw_data  (tw_data),
      .tw_idx   (tw_idx),
      .tw_last  (tw_last),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic longint rnd(input real v);
      return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
   endfunction

   function automatic int clamp(input int s);
      return (s >= LOG2N) ? LOG2N - 1 : s;
   endfunction

   function automatic int ref_k(input int s, input int j);
      return (j % (1 << s)) * (1 << (LOG2N - 1 - s));
   endfunction

   function automatic longint ref_re(input int k);
      return rnd(UNITY * $cos(2.0 * PI * k / N));
   endfunction

   function automatic longint ref_im(input int k, input bit inv);
      longint v;
      v = rnd(-UNITY * $sin(2.0 * PI * k / N));
      return inv ? -v : v;
   endfunction

   function automatic logic pick(input int mode, input int cyc);
      logic [3:0] pat;
      pat = 4'b1001;
      case (mode)
         0:       return 1'b1;
         1:       return pat[3 - (cyc % 4)];
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic do_start(input int s);
      chk("idle_before_start", busy, 0);
      stage = 5'(s);
      start = 1'b1;
`ifdef TWGEN_INV_EN
      inverse = inv_sel;
`endif
      tick;
      start = 1'b0;
      stage = 5'($urandom_range(0, 31));
      chk("busy_after_start", busy, 1);
   endtask

   // Returns at the cycle after the final handshake (the done cycle) for a full run.
   task automatic collect(input int s_in, input int mode, input int stop_after, input bit poke);
      int s, cnt, cyc, lat, k;
      bit stalled;
      logic [2*DW-1:0] hold_data;
      logic [LOG2N-2:0] hold_idx;
      logic hold_last;
      s   = clamp(s_in);
      lat = 0;
      while (!tw_valid && lat < 10) begin
         tw_ready = pick(mode, lat);
         tick;
         lat++;
      end
      chk("first_valid_latency", lat, 2);
      cnt = 0; cyc = 0; stalled = 0;
      hold_data = '0; hold_idx = '0; hold_last = 1'b0;
      while (cnt < stop_after && cyc < 400) begin
         tw_ready = pick(mode, cyc);
         start    = poke && (cnt == 3);
         if (stalled) begin
            chk("hold_valid", tw_valid, 1);
            chk("hold_data", tw_data, hold_data);
            chk("hold_idx", tw_idx, hold_idx);
            chk("hold_last", tw_last, hold_last);
         end
         if (tw_valid && tw_ready) begin
            k = ref_k(s, cnt);
            chk("idx", tw_idx, k);
            chk("re", $signed(tw_data[2*DW-1:DW]), ref_re(k));
            chk("im", $signed(tw_data[DW-1:0]), ref_im(k, inv_sel));
            chk("last", tw_last, (cnt == HALF - 1) ? 1 : 0);
            chk("busy_during", busy, 1);
            cnt++;
         end
         stalled   = tw_valid && !tw_ready;
         hold_data = tw_data;
         hold_idx  = tw_idx;
         hold_last = tw_last;
         tick;
         cyc++;
      end
      start    = 1'b0;
      tw_ready = 1'b1;
      chk("handshake_count", cnt, stop_after);
      if (stop_after == HALF) begin
         chk("done_pulse", done, 1);
         chk("busy_clear", busy, 0);
         chk("valid_clear", tw_valid, 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stage = '0; tw_ready = 1'b1; inv_sel = 1'b0;
`ifdef TWGEN_INV_EN
      inverse = 1'b0;
`endif
      repeat (3) tick;
      chk("rst_busy", busy, 0);
      chk("rst_valid", tw_valid, 0);
      chk("rst_data", tw_data, 0);
      chk("rst_idx", tw_idx, 0);
      chk("rst_last", tw_last, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      tick;

      // Full stage, then stages whose k pattern repeats, and a clamped stage.
      do_start(3); collect(3, 0, HALF, 0); tick;
      chk("done_one_cycle", done, 0);
      do_start(1); collect(1, 0, HALF, 0); tick;
      do_start(0); collect(0, 0, HALF, 0); tick;
      do_start(7); collect(7, 0, HALF, 0); tick;

      // Back-pressure with the 1,0,0,1 ready pattern.
      do_start(3); collect(3, 1, HALF, 0); tick;

      // Start pulsed mid-sequence is ignored.
      do_start(2); collect(2, 0, HALF, 1); tick;
      chk("no_restart_busy", busy, 0);
      chk("no_restart_valid", tw_valid, 0);

      // Start in the done cycle begins a new sequence immediately.
      do_start(3); collect(3, 0, HALF, 0);
      do_start(1); collect(1, 0, HALF, 0); tick;

      // Reset while the third word is on the output.
      do_start(3); collect(3, 0, 2, 0);
      chk("pre_rst_valid", tw_valid, 1);
      rst = 1'b1;
      tick;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", tw_valid, 0);
      chk("mid_rst_data", tw_data, 0);
      chk("mid_rst_idx", tw_idx, 0);
      chk("mid_rst_last", tw_last, 0);
      chk("mid_rst_done", done, 0);
      rst = 1'b0;
      tick;
      chk("post_rst_done", done, 0);
      do_start(3); collect(3, 0, HALF, 0); tick;

`ifdef TWGEN_INV_EN
      inv_sel = 1'b1;
      do_start(3); collect(3, 0, HALF, 0); tick;
      inv_sel = 1'b0;
`endif

      // Randomized stage, back-pressure mode and direction.
      for (int r = 0; r < 10; r++) begin
         int s_r, m_r;
         s_r = $urandom_range(0, 31);
         m_r = $urandom_range(0, 2);
`ifdef TWGEN_INV_EN
         inv_sel = 1'($urandom_range(0, 1));
`endif
         do_start(s_r);
         collect(s_r, m_r, HALF, 0);
         tick;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
